// File: rtl/cpu_bus_arbiter_pkg.sv
// cpu_bus_arbiter_pkg: bus widths, read/write levels, FSM state and owner encodings.
package cpu_bus_arbiter_pkg;
  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  typedef enum logic [1:0] {IDLE, WAIT, OWN} arb_state_e;
  typedef enum logic {ARB_OWN_IF, ARB_OWN_MEM} arb_owner_e;
endpackage

// File: rtl/cpu_bus_prio.sv
// cpu_bus_prio: owner selection with MEM priority and IF anti-starvation counter.
module cpu_bus_prio
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req_,
  input  logic       mem_req_,
  input  logic       sel,
  output arb_owner_e owner
);
  logic [2:0] starve_cnt;
  logic       mem_win;
  assign mem_win = !mem_req_ && (if_req_ || starve_cnt != 3'(STARVE_MAX));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= ARB_OWN_IF;
      starve_cnt <= '0;
    end else if (sel) begin
      owner <= mem_win ? ARB_OWN_MEM : ARB_OWN_IF;
      if (!mem_win) starve_cnt <= '0;
      else if (!if_req_ && starve_cnt != 3'(STARVE_MAX)) starve_cnt <= starve_cnt + 3'd1;
    end
  end
endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: merges IF and MEM bus masters onto one system-bus master port.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_req_,
  output logic                   if_grnt_,
  input  logic [WORD_ADDR_W-1:0] if_addr,
  input  logic                   if_as_,
  input  logic                   if_rw,
  input  logic [WORD_DATA_W-1:0] if_wr_data,
  output logic                   if_rdy_,
  input  logic                   mem_req_,
  output logic                   mem_grnt_,
  input  logic [WORD_ADDR_W-1:0] mem_addr,
  input  logic                   mem_as_,
  input  logic                   mem_rw,
  input  logic [WORD_DATA_W-1:0] mem_wr_data,
  output logic                   mem_rdy_,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  input  logic                   bus_rdy_
);
  arb_state_e state;
  arb_owner_e owner;
  logic       sel, owner_req_, own_if, own_mem;
  assign sel        = state == IDLE && (!if_req_ || !mem_req_);
  assign owner_req_ = owner == ARB_OWN_IF ? if_req_ : mem_req_;
  assign own_if     = state == OWN && owner == ARB_OWN_IF;
  assign own_mem    = state == OWN && owner == ARB_OWN_MEM;
  cpu_bus_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk      (clk),
    .reset    (reset),
    .if_req_  (if_req_),
    .mem_req_ (mem_req_),
    .sel      (sel),
    .owner    (owner)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bus_req_  <= 1'b1;
      if_grnt_  <= 1'b1;
      mem_grnt_ <= 1'b1;
    end else begin
      case (state)
        IDLE: if (sel) begin
          bus_req_ <= 1'b0;
          state    <= WAIT;
        end
        WAIT: if (owner_req_) begin
          bus_req_ <= 1'b1;
          state    <= IDLE;
        end else if (!bus_grnt_) begin
          if_grnt_  <= owner != ARB_OWN_IF;
          mem_grnt_ <= owner != ARB_OWN_MEM;
          state     <= OWN;
        end
        OWN: if (owner_req_) begin
          if_grnt_  <= 1'b1;
          mem_grnt_ <= 1'b1;
          bus_req_  <= 1'b1;
          state     <= IDLE;
        end else if (bus_grnt_) begin
          if_grnt_  <= 1'b1;
          mem_grnt_ <= 1'b1;
          state     <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Outside OWN the system bus sees an idle read with everything zeroed.
  always_comb begin
    bus_addr    = own_if ? if_addr    : own_mem ? mem_addr    : '0;
    bus_as_     = own_if ? if_as_     : own_mem ? mem_as_     : 1'b1;
    bus_rw      = own_if ? if_rw      : own_mem ? mem_rw      : READ;
    bus_wr_data = own_if ? if_wr_data : own_mem ? mem_wr_data : '0;
    if_rdy_     = own_if  ? bus_rdy_ : 1'b1;
    mem_rdy_    = own_mem ? bus_rdy_ : 1'b1;
  end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed checks of grant timing, starvation order, revocation and reset.
module tb_cpu_bus_arbiter;
  import cpu_bus_arbiter_pkg::*;
  logic clk = 0, reset = 1;
  logic if_req_ = 1, mem_req_ = 1, if_as_ = 1, mem_as_ = 1, if_rw = READ, mem_rw = READ;
  logic [WORD_ADDR_W-1:0] if_addr = '0, mem_addr = '0, bus_addr;
  logic [WORD_DATA_W-1:0] if_wr_data = '0, mem_wr_data = '0, bus_wr_data;
  logic bus_grnt_ = 1, bus_rdy_ = 1;
  logic if_grnt_, mem_grnt_, if_rdy_, mem_rdy_, bus_req_, bus_as_, bus_rw;
  int checks = 0, errors = 0;
  cpu_bus_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_(if_req_), .if_grnt_(if_grnt_), .if_addr(if_addr), .if_as_(if_as_),
    .if_rw(if_rw), .if_wr_data(if_wr_data), .if_rdy_(if_rdy_),
    .mem_req_(mem_req_), .mem_grnt_(mem_grnt_), .mem_addr(mem_addr), .mem_as_(mem_as_),
    .mem_rw(mem_rw), .mem_wr_data(mem_wr_data), .mem_rdy_(mem_rdy_),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rdy_(bus_rdy_)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    logic who, prev;
    int n;
    step();
    step();
    chk("rst_bus_req", 32'(bus_req_), 1);
    chk("rst_grants", {if_grnt_, mem_grnt_}, 2'b11);
    chk("rst_bus_as", 32'(bus_as_), 1);
    chk("rst_rdy", {if_rdy_, mem_rdy_}, 2'b11);
    reset = 0;
    step();
    // MEM alone, system grant returned two cycles after bus_req_
    mem_req_ = 0;
    step();
    chk("c1_bus_req", 32'(bus_req_), 0);
    chk("c1_mem_grnt", 32'(mem_grnt_), 1);
    step();
    chk("c2_mem_grnt", 32'(mem_grnt_), 1);
    step();
    bus_grnt_ = 0;
    chk("c3_mem_grnt", 32'(mem_grnt_), 1);
    step();
    chk("c4_mem_grnt", 32'(mem_grnt_), 0);
    chk("c4_if_grnt", 32'(if_grnt_), 1);
    mem_addr = 30'h123_4567;
    mem_as_ = 0;
    if_addr = 30'h0AB_CDEF;
    bus_rdy_ = 0;
    #1;
    chk("own_bus_addr", 32'(bus_addr), 32'h123_4567);
    chk("own_bus_as", 32'(bus_as_), 0);
    chk("own_mem_rdy", 32'(mem_rdy_), 0);
    chk("own_if_rdy", 32'(if_rdy_), 1);
    mem_req_ = 1;
    mem_as_ = 1;
    bus_rdy_ = 1;
    step();
    chk("rel_mem_grnt", 32'(mem_grnt_), 1);
    chk("rel_bus_req", 32'(bus_req_), 1);
    chk("idle_bus_addr", 32'(bus_addr), 0);
    // both masters active: MEM x4 then IF, repeating
    if_req_ = 0;
    mem_req_ = 0;
    for (int t = 0; t < 10; t++) begin
      n = 0;
      while (if_grnt_ && mem_grnt_ && n < 8) begin
        step();
        n++;
      end
      chk("grant_timeout", 32'(n < 8), 1);
      chk("grant_latency", n, 2);
      who = !mem_grnt_;
      chk("grant_order", 32'(who), (t % 5 == 4) ? 0 : 1);
      step();
      step();
      if (who) mem_req_ = 1; else if_req_ = 1;
      step();
      if_req_ = 0;
      mem_req_ = 0;
    end
    if_req_ = 1;
    mem_req_ = 1;
    step();
    step();
    // IF owner with upstream revocation
    if_req_ = 0;
    step();
    step();
    chk("rev_if_grnt0", 32'(if_grnt_), 0);
    bus_grnt_ = 1;
    step();
    chk("rev_if_grnt_hi", 32'(if_grnt_), 1);
    chk("rev_bus_req_lo", 32'(bus_req_), 0);
    bus_grnt_ = 0;
    step();
    chk("rev_if_grnt_back", 32'(if_grnt_), 0);
    if_req_ = 1;
    step();
    chk("rev_release", {if_grnt_, bus_req_}, 2'b11);
    // owner drops request while waiting
    bus_grnt_ = 1;
    mem_req_ = 0;
    step();
    chk("abort_bus_req0", 32'(bus_req_), 0);
    mem_req_ = 1;
    step();
    chk("abort_bus_req1", 32'(bus_req_), 1);
    chk("abort_grants", {if_grnt_, mem_grnt_}, 2'b11);
    step();
    chk("abort_grants2", {if_grnt_, mem_grnt_, bus_req_}, 3'b111);
    // reset in the middle of a MEM write
    if_req_ = 0;
    mem_req_ = 0;
    bus_grnt_ = 0;
    step();
    step();
    chk("wr_mem_grnt", 32'(mem_grnt_), 0);
    mem_as_ = 0;
    mem_rw = WRITE;
    mem_wr_data = 32'hDEAD_BEEF;
    #1;
    chk("wr_bus_as", 32'(bus_as_), 0);
    chk("wr_bus_rw", 32'(bus_rw), 32'(WRITE));
    chk("wr_bus_data", bus_wr_data, 32'hDEAD_BEEF);
    chk("wr_starve", 32'(dut.u_prio.starve_cnt), 1);
    #1 reset = 1;
    #1;
    chk("arst_grants", {if_grnt_, mem_grnt_, bus_req_}, 3'b111);
    chk("arst_bus_as", 32'(bus_as_), 1);
    chk("arst_bus_data", bus_wr_data, 0);
    chk("arst_starve", 32'(dut.u_prio.starve_cnt), 0);
    #1 reset = 0;
    if_req_ = 1;
    mem_as_ = 1;
    mem_rw = READ;
    step();
    chk("post_rst_bus_req", 32'(bus_req_), 0);
    chk("post_rst_grnt", 32'(mem_grnt_), 1);
    step();
    chk("post_rst_grnt2", 32'(mem_grnt_), 0);
    mem_req_ = 1;
    step();
    // random traffic: mutual exclusion, grant after bus_req_, non-owner ready idle
    for (int i = 0; i < 400; i++) begin
      prev = bus_req_;
      if_req_ = 1'($urandom_range(0, 3) == 0);
      mem_req_ = 1'($urandom_range(0, 3) == 0);
      bus_grnt_ = 1'($urandom_range(0, 4) == 0);
      bus_rdy_ = 1'($urandom);
      step();
      chk("rnd_excl", 32'(if_grnt_ || mem_grnt_), 1);
      chk("rnd_prev_req", 32'((if_grnt_ && mem_grnt_) || !prev), 1);
      chk("rnd_if_rdy", 32'(!if_grnt_ || if_rdy_), 1);
      chk("rnd_mem_rdy", 32'(!mem_grnt_ || mem_rdy_), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: number of consecutive MEM wins over a pending IF request before IF is forced to win; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 {if,mem}_req_  in  1  active-low bus request from the IF-stage and MEM-stage bus_if masters.
REQ-005 {if,mem}_grnt_  out  1  active-low grant to each internal master, registered.
REQ-006 {if,mem}_addr  in  `WordAddrBus  word address from each master.
REQ-007 {if,mem}_as_  in  1  active-low address strobe from each master.
REQ-008 {if,mem}_rw  in  1  read/write from each master (`READ / `WRITE).
REQ-009 {if,mem}_wr_data  in  `WordDataBus  write data from each master.
REQ-010 {if,mem}_rdy_  out  1  active-low ready routed to each master.
REQ-011 bus_req_  out  1  active-low request to the system bus arbiter, registered.
REQ-012 bus_grnt_  in  1  active-low grant from the system bus arbiter.
REQ-013 bus_addr, bus_as_, bus_rw, bus_wr_data  out  as above  merged system-bus master signals.
REQ-014 bus_rdy_  in  1  active-low ready from the system bus; bus_rd_data fans out directly and does not pass through this block.

Function
REQ-015 FSM states: IDLE, WAIT (upstream request pending, owner fixed), OWN (grant forwarded to owner).
REQ-016 IDLE: if either req_ is low, the block latches the owner per REQ-021, drives bus_req_=0 next cycle, and moves to WAIT; otherwise it stays in IDLE.
REQ-017 WAIT: if bus_grnt_=0 and owner req_=0, the owner grnt_ goes to 0 next cycle and the FSM moves to OWN; if owner req_=1, bus_req_ goes to 1 and the FSM moves to IDLE.
REQ-018 OWN: when owner req_=1, the owner grnt_ and bus_req_ go to 1 next cycle and the FSM moves to IDLE; the owner never changes while in WAIT or OWN.
REQ-019 OWN with bus_grnt_=1 (upstream revocation): the owner grnt_ goes to 1 next cycle, bus_req_ stays at 0, and the FSM moves to WAIT.
REQ-020 Latency: req_ low at cycle 0 in IDLE -> bus_req_ low at cycle 1; bus_grnt_ low sampled at cycle k -> owner grnt_ low at cycle k+1; minimum 2 cycles from request to grant.
REQ-021 Owner selection: MEM wins over IF when both are requesting, unless starve_cnt==STARVE_MAX, in which case IF wins; a single requester always wins.
REQ-022 starve_cnt (3 bits): +1 when MEM is selected while if_req_=0, saturating at STARVE_MAX; cleared when IF is selected; unchanged when MEM is selected alone.
REQ-023 OWN: bus_addr/as_/rw/wr_data are a combinational mux of the owner's signals; owner rdy_=bus_rdy_; non-owner rdy_=1.
REQ-024 IDLE/WAIT: bus_as_=1, bus_rw=`READ, bus_addr=0, bus_wr_data=0, and both rdy_=1.
REQ-025 At most one of if_grnt_/mem_grnt_ is low in any cycle; a grant is never low unless bus_req_ was low in the preceding cycle.
REQ-026 A non-owner request arriving during WAIT/OWN is held pending and is arbitrated on the next return to IDLE.

Reset
REQ-027 While reset=1: FSM=IDLE, owner=IF, starve_cnt=0, bus_req_=1, if_grnt_=mem_grnt_=1, and all outputs per REQ-024; takes effect asynchronously.
REQ-028 Reset asserted mid-transfer drops all grants and bus_req_ immediately; the first request after deassertion follows REQ-020 timing.

Structure
REQ-029 The state encodings (`ArbStateBus, IDLE/WAIT/OWN) and owner encodings (`ARB_OWN_IF/`ARB_OWN_MEM) belong in cpu.vh; widths come from stddef.vh.
REQ-030 Owner selection and starve_cnt live in sub-module cpu_bus_prio (inputs: both req_, a select strobe, clk, reset; output: owner); the FSM and mux stay in cpu_bus_arbiter.

Verification
REQ-031 mem_req_ only, bus_grnt_ returned 2 cycles after bus_req_ -> mem_grnt_ low at cycle 4; bus_addr equals mem_addr during OWN; if_rdy_ stays 1.
REQ-032 Both requesters continuously active, each transfer releasing req_ after 3 cycles, STARVE_MAX=4 -> grant order MEM,MEM,MEM,MEM,IF, repeating.
REQ-033 Owner IF in OWN, bus_grnt_ pulsed high for 1 cycle -> if_grnt_ high for at least 1 cycle, bus_req_ held low, if_grnt_ reasserted after the grant returns.
REQ-034 Owner releases req_ during WAIT -> bus_req_ high next cycle, no grant is ever issued, FSM returns to IDLE.
REQ-035 reset pulsed while OWN with a write in progress -> both grants and bus_req_ go high with no clock edge; bus_as_=1; starve_cnt=0.
REQ-036 Random stimulus with assertions -> REQ-025 is never violated and the non-owner rdy_ is always 1.
